// File: rtl/div16_seq_if.sv
// Request/response bundle for the sequential divider: operands and start from
// the execute stage, registered quotient/remainder and status back.
interface div16_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             divZero;

  // start is a request sampled only while the divider is idle or presenting a
  // result (done cycle); done is a one-cycle pulse qualifying quot/rem/divZero.
  modport master (
    output start, sgn, inA, inB,
    input  quot, rem, busy, done, divZero
  );

  modport slave (
    input  start, sgn, inA, inB,
    output quot, rem, busy, done, divZero
  );
endinterface

// File: rtl/div16_seq.sv
// Restoring shift-subtract divider, one quotient bit per clock, unsigned or
// two's-complement signed; quotient truncates toward zero, remainder follows dividend.
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  div16_seq_if.slave bus,
  output logic [1:0] stateDbg
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH:0]   partRem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] origA;
  logic             qSign;
  logic             rSign;
  logic             pendZero;

  logic             accept;
  logic             lastIter;
  logic             inBZero;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             trialNeg;
  logic [WIDTH:0]   newRem;
  logic [WIDTH-1:0] newDvd;
  logic [WIDTH-1:0] remMag;
  logic [WIDTH-1:0] quotOut;
  logic [WIDTH-1:0] remOut;

  assign stateDbg = state;

  // A zero divide sits in DONE for one busy cycle (pendZero) before its result
  // cycle, so new requests are only taken once that result is on the outputs.
  assign accept   = bus.start && ((state == IDLE) || ((state == DONE) && !pendZero));
  assign lastIter = (cnt == CNTW'(WIDTH - 1));
  assign inBZero  = (bus.inB == '0);

  // Magnitude of the most negative value wraps back to itself, which is the
  // correct unsigned magnitude.
  assign magA = (bus.sgn && bus.inA[WIDTH-1]) ? (~bus.inA + 1'b1) : bus.inA;
  assign magB = (bus.sgn && bus.inB[WIDTH-1]) ? (~bus.inB + 1'b1) : bus.inB;

  assign shifted  = {partRem[WIDTH-1:0], dvd[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvsr};
  assign trialNeg = diff[WIDTH+1];
  assign newRem   = trialNeg ? shifted : diff[WIDTH:0];
  assign newDvd   = {dvd[WIDTH-2:0], ~trialNeg};
  assign remMag   = newRem[WIDTH-1:0];
  assign quotOut  = qSign ? (~newDvd + 1'b1) : newDvd;
  assign remOut   = rSign ? (~remMag + 1'b1) : remMag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) nextState = inBZero ? DONE : CALC;
      end
      CALC: begin
        if (lastIter) nextState = DONE;
      end
      DONE: begin
        if (pendZero)    nextState = DONE;
        else if (accept) nextState = inBZero ? DONE : CALC;
        else             nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      partRem     <= '0;
      dvd         <= '0;
      dvsr        <= '0;
      origA       <= '0;
      qSign       <= 1'b0;
      rSign       <= 1'b0;
      pendZero    <= 1'b0;
      bus.quot    <= '0;
      bus.rem     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.divZero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        qSign       <= bus.sgn & (bus.inA[WIDTH-1] ^ bus.inB[WIDTH-1]);
        rSign       <= bus.sgn & bus.inA[WIDTH-1];
        dvd         <= magA;
        dvsr        <= magB;
        origA       <= bus.inA;
        partRem     <= '0;
        cnt         <= '0;
        pendZero    <= inBZero;
        bus.busy    <= 1'b1;
        bus.divZero <= 1'b0;
      end else if (state == CALC) begin
        partRem <= newRem;
        dvd     <= newDvd;
        cnt     <= cnt + 1'b1;
        if (lastIter) begin
          bus.quot <= quotOut;
          bus.rem  <= remOut;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
        end
      end else if ((state == DONE) && pendZero) begin
        // Zero divisor reports the raw dividend, independent of sgn.
        bus.quot    <= '1;
        bus.rem     <= origA;
        bus.divZero <= 1'b1;
        bus.done    <= 1'b1;
        bus.busy    <= 1'b0;
        pendZero    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed vector table, handshake and reset
// corner sequences, and randomized operands against an integer-arithmetic model.
module tb_div16_seq;

  logic       clk;
  logic       rst_n;
  logic [1:0] stateDbg;

  div16_seq_if #(.WIDTH(16)) bus ();

  div16_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .stateDbg (stateDbg)
  );

  int vecs = 0;
  int miscompares = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } vecT;

  vecT vecTab[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; SV int / and % truncate toward zero and
  // give the remainder the dividend's sign.
  function automatic logic [32:0] refDiv(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa;
    int sb;
    logic [15:0] q;
    logic [15:0] r;
    if (b == 16'h0000) return {1'b1, 16'hFFFF, a};
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // One complete request; lat counts edges after the sampling edge until done.
  task automatic doDiv(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic z, output int lat);
    @(negedge clk);
    bus.inA = a; bus.inB = b; bus.sgn = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.quot; r = bus.rem; z = bus.divZero;
    check("busy_in_done_cycle", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    check("done_single_cycle", {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [15:0] q, r;
    logic        z;
    int          lat;
    int          n;
    int          sawDone;
    logic [32:0] e;
    logic [15:0] a, b;
    logic        s;

    vecTab[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 16};
    vecTab[1]  = '{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 16};
    vecTab[2]  = '{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 16};
    vecTab[3]  = '{16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'h0000, 1'b0, 16};
    vecTab[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 16};
    vecTab[5]  = '{16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0, 16};
    vecTab[6]  = '{16'h04D2, 16'd0,    1'b0, 16'hFFFF, 16'h04D2, 1'b1, 1};
    vecTab[7]  = '{16'd20,   16'd4,    1'b0, 16'd5,    16'd0,    1'b0, 16};
    vecTab[8]  = '{16'hFFF9, 16'hFFFE, 1'b1, 16'd3,    16'hFFFF, 1'b0, 16};
    vecTab[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'd1,    16'd0,    1'b0, 16};
    vecTab[10] = '{16'hFFF9, 16'd0,    1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.sgn = 1'b0; bus.inA = '0; bus.inB = '0;
    repeat (3) @(negedge clk);
    check("reset_quot",    {16'b0, bus.quot}, 32'd0);
    check("reset_rem",     {16'b0, bus.rem}, 32'd0);
    check("reset_busy",    {31'b0, bus.busy}, 32'd0);
    check("reset_done",    {31'b0, bus.done}, 32'd0);
    check("reset_divzero", {31'b0, bus.divZero}, 32'd0);
    check("reset_state",   {30'b0, stateDbg}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      doDiv(vecTab[i].a, vecTab[i].b, vecTab[i].s, q, r, z, lat);
      check($sformatf("vec%0d_quot", i), {16'b0, q}, {16'b0, vecTab[i].q});
      check($sformatf("vec%0d_rem", i),  {16'b0, r}, {16'b0, vecTab[i].r});
      check($sformatf("vec%0d_divzero", i), {31'b0, z}, {31'b0, vecTab[i].z});
      check($sformatf("vec%0d_latency", i), lat, vecTab[i].lat);
    end

    // Second start during CALC must be ignored along with its operands.
    @(negedge clk);
    bus.inA = 16'd50000; bus.inB = 16'd7; bus.sgn = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.inA = 16'd9; bus.inB = 16'd3; bus.sgn = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 5;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = refDiv(16'd50000, 16'd7, 1'b0);
    check("ignore_latency", lat, 16);
    check("ignore_quot", {16'b0, bus.quot}, {16'b0, e[31:16]});
    check("ignore_rem",  {16'b0, bus.rem}, {16'b0, e[15:0]});
    @(negedge clk);
    check("ignore_no_restart", {31'b0, bus.busy}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 9) == 0) a = 16'h8000;
      b = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 9) == 0) b = 16'($urandom_range(1, 5));
      s = 1'($urandom_range(0, 1));
      exp_q.push_back(refDiv(a, b, s));
      doDiv(a, b, s, q, r, z, lat);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_quot a=%h b=%h s=%0d", i, a, b, s), {16'b0, q}, {16'b0, e[31:16]});
      check($sformatf("rand%0d_rem", i), {16'b0, r}, {16'b0, e[15:0]});
      check($sformatf("rand%0d_divzero", i), {31'b0, z}, {31'b0, e[32]});
      check($sformatf("rand%0d_latency", i), lat, (b == 16'h0000) ? 16'd1 : 16'd16);
    end

    // Start held high: second op (operands changed mid-CALC) is taken in the done cycle.
    @(negedge clk);
    bus.inA = 16'd1234; bus.inB = 16'd10; bus.sgn = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.inA = 16'hFF00; bus.inB = 16'd3; bus.sgn = 1'b1;
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_latency", lat, 16);
    check("b2b_first_quot", {16'b0, bus.quot}, 32'd123);
    check("b2b_first_rem",  {16'b0, bus.rem}, 32'd4);
    n = 0;
    @(negedge clk);
    n++;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    e = refDiv(16'hFF00, 16'd3, 1'b1);
    check("b2b_period", n, 17);
    check("b2b_second_quot", {16'b0, bus.quot}, {16'b0, e[31:16]});
    check("b2b_second_rem",  {16'b0, bus.rem}, {16'b0, e[15:0]});

    // Reset in the middle of 1000/3 clears everything at once and yields no done.
    @(negedge clk);
    @(negedge clk);
    bus.inA = 16'd1000; bus.inB = 16'd3; bus.sgn = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_quot", {16'b0, bus.quot}, 32'd0);
    check("midrst_rem",  {16'b0, bus.rem}, 32'd0);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_state", {30'b0, stateDbg}, 32'd0);
    sawDone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) sawDone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) sawDone++;
    end
    check("midrst_no_done", sawDone, 0);
    doDiv(16'd1000, 16'd3, 1'b0, q, r, z, lat);
    check("after_rst_quot", {16'b0, q}, 32'd333);
    check("after_rst_rem",  {16'b0, r}, 32'd1);
    check("after_rst_latency", lat, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
